mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS core. Sequences the shared ALU, register file,
//  unified instruction/data memory port and PC over FETCH/DECODE/EXECUTE/MEM/WB steps.
//  Drives ALUOp into the ALU decoder, which keeps its existing encoding:
//  00 = add, 01 = sub, 10 = use the Funct field.
//  Adds a memory ready handshake and a multi-cycle hold for the MUL funct.
// PARAMETERS
//  MUL_CYCLES  4  cycles EXECUTE is held for funct 011100 (mul); legal range 1..15
// PORTS
//  CLK         in   1  single core clock, rising edge
//  RST         in   1  reset, synchronous, active-low
//  Opcode      in   6  IR[31:26]
//  Funct       in   6  IR[5:0]
//  Zero        in   1  ALU zero flag, valid in BRANCH
//  mem_ready   in   1  memory has completed the current access this cycle
//  mem_req     out  1  memory access request, held until mem_ready
//  MemWrite    out  1  write strobe, qualifies mem_req
//  IorD        out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  IRWrite     out  1  load instruction register
//  PCWrite     out  1  load PC (already OR'd with branch-taken)
//  PCSrc       out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//  ALUSrcA     out  1  0 = PC, 1 = register A
//  ALUSrcB     out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//  ALUOp       out  2  to ALU decoder
//  RegWrite    out  1  register file write enable
//  RegDst      out  1  0 = rt, 1 = rd
//  MemtoReg    out  1  0 = ALUOut, 1 = memory data register
//  illegal_op  out  1  one-cycle pulse on an unsupported opcode
// BEHAVIOUR
//  - State register updates on the CLK rising edge.
//  - RST==0 at an edge forces state RST_S. RST_S drives every output 0.
//    This applies from any state, including mid-access or mid-MUL: any pending mem_req drops.
//  - RST_S -> FETCH unconditionally on the first edge with RST==1.
//  - Outputs are combinational from the state plus mem_ready/Zero.
//    Any output not listed for a state is 0.
//  - FETCH:   mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
//             If mem_ready: IRWrite=1, PCWrite=1, PCSrc=00, then -> DECODE. Otherwise stay.
//  - DECODE:  ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
//             100011 or 101011 -> MEMADR
//             000000 -> EXEC
//             000100 -> BRANCH
//             001000 -> ADDIEX
//             000010 -> JUMP
//             any other -> FETCH, with illegal_op=1 for this cycle.
//  - MEMADR:  ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMRD if lw, -> MEMWR if sw.
//  - MEMRD:   mem_req=1, IorD=1. Wait for mem_ready, then -> MEMWB.
//  - MEMWB:   RegWrite=1, RegDst=0, MemtoReg=1. -> FETCH.
//  - MEMWR:   mem_req=1, MemWrite=1, IorD=1. Wait for mem_ready, then -> FETCH.
//  - EXEC:    ALUSrcA=1, ALUSrcB=00, ALUOp=10.
//             Funct!=011100: -> ALUWB.
//             Funct==011100: a 4-bit counter loads MUL_CYCLES-1 on entry.
//             Stay while count!=0, decrementing each cycle; -> ALUWB at count==0.
//             MUL_CYCLES==1 behaves like a normal R-type.
//  - ALUWB:   RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
//  - BRANCH:  ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero. -> FETCH.
//  - ADDIEX:  ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
//  - ADDIWB:  RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
//  - JUMP:    PCSrc=10, PCWrite=1. -> FETCH.
//  - Handshake rules:
//    - While waiting, mem_req and the other memory controls stay stable.
//    - A mem_ready seen with mem_req==0 is ignored.
//    - No timeout: the FSM waits indefinitely.
//  - CPI with zero-wait memory:
//    lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, mul 3+MUL_CYCLES.
//  - Encoding: one-hot or binary is free. Unreachable states recover to FETCH on the next edge.
// TESTING
//  - Reset: RST=0 for 2 edges mid-MEMRD -> all outputs 0.
//    After RST=1, the first FETCH follows one cycle in RST_S.
//  - lw, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
//    RegWrite=1 with MemtoReg=1 only in cycle 5.
//  - sw with mem_ready low 3 cycles in MEMWR -> mem_req=MemWrite=IorD=1 held for 4 cycles.
//    Single exit to FETCH; RegWrite never asserted.
//  - R-type Funct=100000 takes 4 cycles; Funct=011100 with MUL_CYCLES=4 takes 7 cycles.
//    ALUOp=10 throughout EXEC.
//  - beq: Zero=1 -> PCWrite=1 with PCSrc=01 in BRANCH; Zero=0 -> PCWrite=0. Both return to FETCH.
//  - Opcode=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no write enables.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core.
// Sequences the shared ALU, the register file, the unified memory port and the PC.
// Each instruction walks through FETCH/DECODE/EXECUTE/MEM/WB steps.
// Memory accesses use a req/ready handshake. The MUL funct holds EXECUTE for MUL_CYCLES cycles.
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-low reset
//   Opcode, Funct            instruction fields IR[31:26], IR[5:0]
//   Zero                     ALU zero flag, used in BRANCH
//   mem_ready                memory completed the current access this cycle
//   mem_req/MemWrite/IorD    memory request, write strobe, address select
//   IRWrite/PCWrite/PCSrc    instruction register and PC update controls
//   ALUSrcA/ALUSrcB/ALUOp    ALU operand selects and ALU decoder opcode
//   RegWrite/RegDst/MemtoReg register file write controls
//   illegal_op               one-cycle pulse on an unsupported opcode
module mips_multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal_op
);

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnMul   = 6'b011100;

  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StRst;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        // Counter is preloaded on every EXEC entry; only MUL consumes it.
        cnt_d = MulLoad;
        case (Opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (Opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec: begin
        if (Funct == FnMul && cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StAluWb;
        end
      end
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: illegal_op = 1'b0;
          default:                                 illegal_op = 1'b1;
        endcase
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCWrite = Zero;
      end
      StAddiWb: RegWrite = 1'b1;
      StJump: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle by cycle
// and compares the full control-output vector against hand-built per-state constants.
module tb_mips_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegWrite, RegDst, MemtoReg, illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.MUL_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Opcode     (Opcode),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .illegal_op (illegal_op)
  );

  // Vector order: mem_req MemWrite IorD IRWrite PCWrite PCSrc[2] ALUSrcA ALUSrcB[2] ALUOp[2]
  //               RegWrite RegDst MemtoReg illegal_op
  logic [16:0] obs;
  assign obs = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                RegWrite, RegDst, MemtoReg, illegal_op};

  //                                   req wr iod irw pcw pcs  a  srcb op  rw rd m2r ill
  localparam logic [16:0] VZero    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b0000};
  localparam logic [16:0] VFetchW  = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,4'b0000};
  localparam logic [16:0] VFetchR  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b00,4'b0000};
  localparam logic [16:0] VDecode  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,4'b0000};
  localparam logic [16:0] VDecIll  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,4'b0001};
  localparam logic [16:0] VMemAdr  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,4'b0000};
  localparam logic [16:0] VMemRd   = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b0000};
  localparam logic [16:0] VMemWb   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b1010};
  localparam logic [16:0] VMemWr   = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b0000};
  localparam logic [16:0] VExec    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,4'b0000};
  localparam logic [16:0] VAluWb   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b1100};
  localparam logic [16:0] VBrT     = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,4'b0000};
  localparam logic [16:0] VBrNt    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,4'b0000};
  localparam logic [16:0] VAddiWb  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,4'b1000};
  localparam logic [16:0] VJump    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,4'b0000};

  // Check the outputs for the current state, then advance one clock.
  // Called 1 time unit after a rising edge, samples 1 unit later, returns 1 unit after next edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset state, then the single RST_S cycle before FETCH.
    cyc("reset_hold", VZero);
    RST = 1'b1;
    cyc("rst_s_once", VZero);

    // lw with mem_ready tied high.
    mem_ready = 1'b1; Opcode = 6'b100011;
    cyc("lw_fetch", VFetchR);
    cyc("lw_decode", VDecode);
    cyc("lw_memadr", VMemAdr);
    cyc("lw_memrd", VMemRd);
    cyc("lw_memwb", VMemWb);

    // sw: FETCH waits one cycle, MEMWR waits three.
    Opcode = 6'b101011; mem_ready = 1'b0;
    cyc("sw_fetch_wait", VFetchW);
    mem_ready = 1'b1;
    cyc("sw_fetch", VFetchR);
    cyc("sw_decode", VDecode);
    cyc("sw_memadr", VMemAdr);
    mem_ready = 1'b0;
    cyc("sw_memwr_w1", VMemWr);
    cyc("sw_memwr_w2", VMemWr);
    cyc("sw_memwr_w3", VMemWr);
    mem_ready = 1'b1;
    cyc("sw_memwr_done", VMemWr);

    // R-type add: 4 cycles.
    Opcode = 6'b000000; Funct = 6'b100000;
    cyc("add_fetch", VFetchR);
    cyc("add_decode", VDecode);
    cyc("add_exec", VExec);
    cyc("add_aluwb", VAluWb);

    // mul with MUL_CYCLES=4: EXEC held for 4 cycles, 7 total.
    Funct = 6'b011100;
    cyc("mul_fetch", VFetchR);
    cyc("mul_decode", VDecode);
    cyc("mul_exec1", VExec);
    cyc("mul_exec2", VExec);
    cyc("mul_exec3", VExec);
    cyc("mul_exec4", VExec);
    cyc("mul_aluwb", VAluWb);

    // beq taken and not taken.
    Opcode = 6'b000100; Funct = 6'd0; Zero = 1'b1;
    cyc("beq_t_fetch", VFetchR);
    cyc("beq_t_decode", VDecode);
    cyc("beq_t_branch", VBrT);
    Zero = 1'b0;
    cyc("beq_nt_fetch", VFetchR);
    cyc("beq_nt_decode", VDecode);
    cyc("beq_nt_branch", VBrNt);

    // addi and j.
    Opcode = 6'b001000;
    cyc("addi_fetch", VFetchR);
    cyc("addi_decode", VDecode);
    cyc("addi_ex", VMemAdr);
    cyc("addi_wb", VAddiWb);
    Opcode = 6'b000010;
    cyc("j_fetch", VFetchR);
    cyc("j_decode", VDecode);
    cyc("j_jump", VJump);

    // Unsupported opcode: one-cycle illegal_op pulse, straight back to FETCH.
    Opcode = 6'b111111;
    cyc("ill_fetch", VFetchR);
    cyc("ill_decode", VDecIll);
    mem_ready = 1'b0;
    cyc("ill_back_fetch", VFetchW);

    // Reset asserted for two edges in the middle of a stalled MEMRD.
    Opcode = 6'b100011; mem_ready = 1'b1;
    cyc("rlw_fetch", VFetchR);
    cyc("rlw_decode", VDecode);
    cyc("rlw_memadr", VMemAdr);
    mem_ready = 1'b0;
    cyc("rlw_memrd_wait", VMemRd);
    RST = 1'b0;
    cyc("rlw_memrd_rst", VMemRd);
    mem_ready = 1'b1;
    cyc("rlw_rst_edge1", VZero);
    RST = 1'b1;
    cyc("rlw_rst_s", VZero);
    mem_ready = 1'b0;
    cyc("rlw_fetch_after", VFetchW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
